// File: rtl/contention_arbiter_n.sv
// contention_arbiter_n: arbitrates N_CH pixel channels onto one z-buffer port.
// Highest-fill with age-based forcing (MODE 0) or round-robin (MODE 1); IDLE/SEND/ACK handshake.
module contention_arbiter_n #(
    parameter int N_CH        = 4,
    parameter int PIXEL_WIDTH = 8,
    parameter int LENGTH      = 8,
    parameter int MODE        = 0,
    parameter int AGE_LIMIT   = 3,
    localparam int IW         = $clog2(N_CH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_CH*PIXEL_WIDTH-1:0] pix_in,
    input  logic [N_CH*LENGTH-1:0]      fill,
    input  logic [N_CH-1:0]             req,
    output logic [N_CH-1:0]             ack,
    input  logic                        rdy_z_buffer,
    output logic                        send_z_buffer,
    output logic [PIXEL_WIDTH-1:0]      pix_out,
    output logic [IW-1:0]               grant_id
);
    typedef enum logic [1:0] {IDLE, SEND, ACK} state_t;

    state_t            state, state_nxt;
    logic [N_CH-1:0]   elig;
    logic [3:0]        age [N_CH];
    logic [IW-1:0]     rr, win, cand;
    logic [LENGTH-1:0] best;
    logic              any, aged;

    for (genvar g = 0; g < N_CH; g++) begin : g_elig
        assign elig[g] = req[g] && (fill[g*LENGTH +: LENGTH] != '0);
    end

    always_comb begin
        win  = '0;
        best = '0;
        cand = '0;
        aged = 1'b0;
        any  = |elig;
        if (MODE == 0) begin
            // Descending scans let the lowest index overwrite on ties.
            for (int i = N_CH-1; i >= 0; i--)
                if (elig[i] && age[i] == 4'(AGE_LIMIT)) begin
                    win  = IW'(i);
                    aged = 1'b1;
                end
            if (!aged)
                for (int i = N_CH-1; i >= 0; i--)
                    if (elig[i] && fill[i*LENGTH +: LENGTH] >= best) begin
                        win  = IW'(i);
                        best = fill[i*LENGTH +: LENGTH];
                    end
        end else begin
            for (int k = N_CH-1; k >= 0; k--) begin
                cand = rr + IW'(k);
                if (elig[cand]) win = cand;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        send_z_buffer = 1'b0;
        ack           = '0;
        case (state)
            IDLE: state_nxt = any ? SEND : IDLE;
            SEND: begin
                send_z_buffer = 1'b1;
                state_nxt     = rdy_z_buffer ? ACK : SEND;
            end
            ACK: begin
                ack       = N_CH'(1) << grant_id;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pix_out  <= '0;
            grant_id <= '0;
            rr       <= '0;
            for (int i = 0; i < N_CH; i++) age[i] <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any) begin
                grant_id <= win;
                pix_out  <= pix_in[win*PIXEL_WIDTH +: PIXEL_WIDTH];
            end
            if (state == ACK) rr <= grant_id + 1'b1;
            // With nothing eligible every age clears, same as a decision with no losers.
            if (state == IDLE)
                for (int i = 0; i < N_CH; i++)
                    if (!elig[i] || (any && IW'(i) == win)) age[i] <= '0;
                    else if (age[i] < 4'(AGE_LIMIT)) age[i] <= age[i] + 4'd1;
        end
    end
endmodule

// File: tb/tb_contention_arbiter_n.sv
// tb_contention_arbiter_n: directed checks of the arbiter, MODE 0 and MODE 1 instances
// driven from the same stimulus.
module tb_contention_arbiter_n;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pix_in = '0;
    logic [31:0] fill = '0;
    logic [3:0]  req = '0;
    logic        rdy = 1'b1;
    logic [3:0]  ack0, ack1;
    logic        send0, send1;
    logic [7:0]  pix0, pix1;
    logic [1:0]  gid0, gid1;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    contention_arbiter_n #(.N_CH(4), .PIXEL_WIDTH(8), .LENGTH(8), .MODE(0), .AGE_LIMIT(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .fill(fill), .req(req), .ack(ack0),
        .rdy_z_buffer(rdy), .send_z_buffer(send0), .pix_out(pix0), .grant_id(gid0));

    contention_arbiter_n #(.N_CH(4), .PIXEL_WIDTH(8), .LENGTH(8), .MODE(1), .AGE_LIMIT(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .fill(fill), .req(req), .ack(ack1),
        .rdy_z_buffer(rdy), .send_z_buffer(send1), .pix_out(pix1), .grant_id(gid1));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req = '0;
        rdy = 1'b1;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_send(input bit which, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (which ? send1 : send0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int n = 0; n < 4; n++) begin
            pix_in = $urandom; fill = $urandom; req = 4'($urandom); rdy = 1'($urandom);
            tick();
        end
        checks += 4;
        if (send0 !== 1'b0) begin errors++; $display("FAIL reset_send got %b want 0", send0); end
        if (ack0 !== 4'b0000) begin errors++; $display("FAIL reset_ack got %b want 0000", ack0); end
        if (pix0 !== 8'h00) begin errors++; $display("FAIL reset_pix got %h want 00", pix0); end
        if (gid0 !== 2'd0) begin errors++; $display("FAIL reset_gid got %0d want 0", gid0); end
        req = '0; pix_in = '0; fill = '0; rdy = 1'b1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single;
        do_reset();
        req = 4'b0100; fill = 32'h0001_0000; pix_in = 32'h0078_0000; rdy = 1'b1;
        tick();
        checks += 4;
        if (send0 !== 1'b1) begin errors++; $display("FAIL single_send got %b want 1", send0); end
        if (pix0 !== 8'h78) begin errors++; $display("FAIL single_pix got %h want 78", pix0); end
        if (gid0 !== 2'd2) begin errors++; $display("FAIL single_gid got %0d want 2", gid0); end
        if (ack0 !== 4'b0000) begin errors++; $display("FAIL single_early_ack got %b want 0000", ack0); end
        tick();
        checks += 2;
        if (ack0 !== 4'b0100) begin errors++; $display("FAIL single_ack got %b want 0100", ack0); end
        if (send0 !== 1'b0) begin errors++; $display("FAIL single_send_drop got %b want 0", send0); end
        req = '0;
        tick();
        checks++;
        if (ack0 !== 4'b0000) begin errors++; $display("FAIL single_ack_once got %b want 0000", ack0); end
    endtask

    task automatic test_fill_priority;
        int eg[4] = '{1, 3, 2, 0};
        logic [7:0] ep[4] = '{8'hA5, 8'h4B, 8'h78, 8'hE2};
        bit ok;
        do_reset();
        pix_in = 32'h4B78_A5E2; fill = 32'h9D7E_AF24; req = 4'b1111; rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_send(1'b0, ok);
            checks += 4;
            if (!ok) begin errors++; $display("FAIL prio_timeout grant %0d got no send want send", i); end
            if (gid0 !== 2'(eg[i])) begin errors++; $display("FAIL prio_gid grant %0d got %0d want %0d", i, gid0, eg[i]); end
            if (pix0 !== ep[i]) begin errors++; $display("FAIL prio_pix grant %0d got %h want %h", i, pix0, ep[i]); end
            tick();
            if (ack0 !== 4'(1 << eg[i])) begin errors++; $display("FAIL prio_ack grant %0d got %b want %b", i, ack0, 4'(1 << eg[i])); end
            req[eg[i]] = 1'b0;
        end
    endtask

    task automatic test_ties;
        int rot[5] = '{0, 1, 2, 3, 0};
        bit ok;
        do_reset();
        pix_in = 32'h4B78_A5E2; fill = 32'h0101_0101; req = 4'b1111; rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_send(1'b1, ok);
            checks += 2;
            if (!ok) begin errors++; $display("FAIL rr_timeout grant %0d got no send want send", i); end
            if (gid1 !== 2'(rot[i])) begin errors++; $display("FAIL rr_gid grant %0d got %0d want %0d", i, gid1, rot[i]); end
            if (i == 0) begin
                checks++;
                if (gid0 !== 2'd0) begin errors++; $display("FAIL tie_gid got %0d want 0", gid0); end
            end
            tick();
        end
        do_reset();
        req = 4'b0001; fill = 32'h0101_0100;
        for (int n = 0; n < 10; n++) begin
            tick();
            checks++;
            if (send0 !== 1'b0 || send1 !== 1'b0) begin
                errors++; $display("FAIL zero_fill cycle %0d got send %b/%b want 0/0", n, send0, send1);
            end
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        do_reset();
        req = 4'b0100; fill = 32'h0001_0000; pix_in = 32'h0078_0000; rdy = 1'b0;
        wait_send(1'b0, ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL bp_timeout got no send want send"); end
        if (gid0 !== 2'd2) begin errors++; $display("FAIL bp_gid got %0d want 2", gid0); end
        pix_in = 32'h0011_0000;
        for (int n = 0; n < 5; n++) begin
            tick();
            checks++;
            if (send0 !== 1'b1 || pix0 !== 8'h78 || ack0 !== 4'b0000) begin
                errors++; $display("FAIL bp_hold cycle %0d got send %b pix %h ack %b want 1 78 0000", n, send0, pix0, ack0);
            end
        end
        rdy = 1'b1;
        tick();
        checks++;
        if (ack0 !== 4'b0100) begin errors++; $display("FAIL bp_ack got %b want 0100", ack0); end
        req = '0;
        tick();
        checks++;
        if (ack0 !== 4'b0000) begin errors++; $display("FAIL bp_ack_once got %b want 0000", ack0); end
    endtask

    task automatic test_aging;
        int eg[4] = '{1, 1, 1, 0};
        bit ok;
        do_reset();
        pix_in = 32'h4B78_A5E2; fill = 32'h0000_FF01; req = 4'b0011; rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_send(1'b0, ok);
            checks += 2;
            if (!ok) begin errors++; $display("FAIL age_timeout grant %0d got no send want send", i); end
            if (gid0 !== 2'(eg[i])) begin errors++; $display("FAIL age_gid grant %0d got %0d want %0d", i, gid0, eg[i]); end
            tick();
        end
        req = '0;
    endtask

    task automatic test_mid_reset;
        bit ok;
        do_reset();
        req = 4'b0100; fill = 32'h0001_0000; pix_in = 32'h0078_0000; rdy = 1'b0;
        wait_send(1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL mr_timeout got no send want send"); end
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (send0 !== 1'b0) begin errors++; $display("FAIL mr_send got %b want 0", send0); end
        if (ack0 !== 4'b0000) begin errors++; $display("FAIL mr_ack got %b want 0000", ack0); end
        if (pix0 !== 8'h00) begin errors++; $display("FAIL mr_pix got %h want 00", pix0); end
        if (gid0 !== 2'd0) begin errors++; $display("FAIL mr_gid got %0d want 0", gid0); end
        req = '0; rdy = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            checks++;
            if (ack0 !== 4'b0000 || send0 !== 1'b0) begin
                errors++; $display("FAIL mr_no_ack cycle %0d got ack %b send %b want 0000 0", n, ack0, send0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_priority();
        test_ties();
        test_backpressure();
        test_aging();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/contention_arbiter_n.md
CONTENTION_ARBITER_N -- requirements
Module: contention_arbiter_n

Interface
REQ-001 Parameter N_CH, default 4, number of input channels; power of two, 2..16.
REQ-002 Parameter PIXEL_WIDTH, default 8, pixel data width.
REQ-003 Parameter LENGTH, default 8, fill-level width, unsigned.
REQ-004 Parameter MODE, default 0, selects the policy: 0 = highest fill wins, 1 = round-robin.
REQ-005 Parameter AGE_LIMIT, default 3, number of lost decisions after which a channel is force-granted; range 1..15.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 pix_in  in  N_CH*PIXEL_WIDTH  channel i pixel in bits [i*PIXEL_WIDTH +: PIXEL_WIDTH].
REQ-009 fill  in  N_CH*LENGTH  channel i FIFO fill level in bits [i*LENGTH +: LENGTH].
REQ-010 req  in  N_CH  channel i holds req[i] high, with a stable pixel, until acked.
REQ-011 ack  out  N_CH  one-cycle pulse to the channel whose pixel was transferred.
REQ-012 rdy_z_buffer  in  1  z-buffer can accept a pixel this cycle.
REQ-013 send_z_buffer  out  1  pix_out is valid and offered to the z-buffer.
REQ-014 pix_out  out  PIXEL_WIDTH  pixel offered to the z-buffer.
REQ-015 grant_id  out  $clog2(N_CH)  index of the channel currently granted.

Function
REQ-016 A channel is eligible when req[i]=1 and fill[i]!=0; a channel with fill=0 is never granted, even if it requests.
REQ-017 The FSM has three states:
- IDLE: evaluates eligibility; if any channel is eligible, latches the winner index into grant_id and its pixel into pix_out, then goes to SEND.
- SEND: send_z_buffer=1; when rdy_z_buffer=1, the transfer occurs on that edge and the FSM goes to ACK; otherwise it stays in SEND.
- ACK: ack[grant_id]=1 for exactly one cycle; the FSM then goes to IDLE.
REQ-018 pix_out and grant_id stay constant from SEND entry until the next IDLE decision; changes on pix_in or req during SEND do not alter the transfer.
REQ-019 If req drops during SEND, the latched pixel is still transferred and still acked.
REQ-020 Latency: eligibility at edge k gives send_z_buffer=1 after edge k; with rdy_z_buffer=1, ack is high after edge k+1; peak throughput is one pixel per 3 cycles.
REQ-021 MODE 0 priority order:
- (a) Any channel whose age counter equals AGE_LIMIT wins; among several, the lowest index wins.
- (b) Otherwise the largest unsigned fill wins.
- (c) Fill ties go to the lowest index.
REQ-022 MODE 1 policy:
- The first eligible channel at or after pointer rr wins; the search wraps from N_CH-1 to 0.
- rr is set to winner+1 (mod N_CH) at the ACK state.
- Aging is ignored.
REQ-023 Age counters, one per channel, 4 bits:
- Incremented at each IDLE decision in which the channel is eligible and not granted.
- Saturate at AGE_LIMIT.
- Cleared when the channel is granted.
- Cleared when the channel is not eligible at a decision.
REQ-024 fill all ones (8'hFF) is compared as unsigned 255; no overflow and no sign handling.
REQ-025 At most one ack bit is high in any cycle; ack is 0 outside ACK.
REQ-026 A channel still requesting after its ack is treated as a new request at the next IDLE decision.

Reset
REQ-027 rst_n=0 asynchronously forces:
- state IDLE
- send_z_buffer=0, ack=0, pix_out=0, grant_id=0
- rr=0, all age counters 0
REQ-028 A reset during SEND or ACK drops the pending transfer; no ack is issued for it after release.
REQ-029 The first decision is made on the first rising edge after rst_n returns to 1.

Verification
Configuration for all scenarios: N_CH=4, PIXEL_WIDTH=8, LENGTH=8, AGE_LIMIT=3.
REQ-030 Reset: hold rst_n=0 with all inputs random -> send_z_buffer=0, ack=4'b0000, pix_out=8'h00, grant_id=0.
REQ-031 Single requester: req=4'b0100, fill_2=8'h01, pix_in_2=8'h78, rdy=1 -> next cycle send=1, pix_out=8'h78, grant_id=2; following cycle ack=4'b0100.
REQ-032 Fill priority (MODE 0): all req=1, pix E2/A5/78/4B, fills 24/AF/7E/9D -> grants in order ch1 (A5), ch3 (4B), ch2 (78), ch0 (E2); ch0 is granted by aging if it reaches age 3 first.
REQ-033 Ties and zero fill:
- All fills 8'h01, all req=1, MODE 0 -> ch0 granted first.
- MODE 1 -> grants rotate 0,1,2,3,0.
- req=4'b0001 with fill_0=8'h00 -> no send ever.
REQ-034 Backpressure: ch2 granted, rdy_z_buffer=0 for 5 cycles, pix_in_2 changed to 8'h11 -> send=1 held, pix_out stays 8'h78, ack=0; rdy=1 -> ack_2 pulses once.
REQ-035 Aging and mid-transfer reset:
- ch1 fill=8'hFF and ch0 fill=8'h01, both requesting continuously -> grants ch1,ch1,ch1,ch0.
- Assert rst_n=0 during SEND -> no ack is issued and outputs match REQ-030.
